// File: rtl/qpsk_modulator.sv
// QPSK frame transmitter: 2-bit symbols in, 9-bit I*sin+Q*cos carrier samples out; one sample per SAMPLE_DIV clocks, output one clock after its strobe.
// sym_ready pulses only at symbol boundaries, and missing symbols mid-frame are replaced by 01; optional TX_FRAME_CNT_EN adds frame/underrun counters.
module qpsk_modulator #(
    parameter int SAMPLE_DIV    = 4,
    parameter int SYM_PER_FRAME = 32,
    parameter int GAP_SAMPLES   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic [8:0] mod_out,
    output logic       sample_stb,
    output logic       busy,
`ifdef TX_FRAME_CNT_EN
    output logic       underrun,
    output logic [7:0] frame_cnt,
    output logic [7:0] underrun_cnt
`else
    output logic       underrun
`endif
);

    // The sine table spans exactly one carrier period of 32 phases.
    localparam int SAMP_PER_SYM = 32;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;
    localparam int GAP_W = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [4:0]       ph_q, ph_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]       sym_q, sym_d;
    logic [8:0]       mod_out_q, mod_out_d;
    logic             stb_q;
    logic             underrun_q, underrun_d;

    logic             strobe;
    logic             last_ph;
    logic             last_sym;
    logic [1:0]       next_sym;

    function automatic logic signed [9:0] sin_lut(input logic [4:0] k);
        logic [3:0]        idx;
        logic [7:0]        mag;
        logic signed [9:0] m;
        idx = k[3] ? (4'd8 - {1'b0, k[2:0]}) : {1'b0, k[2:0]};
        case (idx)
            4'd0:    mag = 8'd0;
            4'd1:    mag = 8'd23;
            4'd2:    mag = 8'd46;
            4'd3:    mag = 8'd67;
            4'd4:    mag = 8'd85;
            4'd5:    mag = 8'd100;
            4'd6:    mag = 8'd111;
            4'd7:    mag = 8'd118;
            default: mag = 8'd120;
        endcase
        m = {2'b00, mag};
        return k[4] ? -m : m;
    endfunction

    // sym[0]=0 negates the sin term, sym[1]=1 negates the cos term.
    function automatic logic [8:0] qpsk_sample(input logic [4:0] ph, input logic [1:0] sym);
        logic signed [9:0] s_t;
        logic signed [9:0] c_t;
        logic signed [9:0] i_t;
        logic signed [9:0] q_t;
        s_t = sin_lut(ph);
        c_t = sin_lut(ph + 5'd8);
        i_t = sym[0] ? s_t : -s_t;
        q_t = sym[1] ? -c_t : c_t;
        return 9'(i_t + q_t);
    endfunction

    assign strobe   = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign last_ph  = (ph_q == 5'(SAMP_PER_SYM - 1));
    assign last_sym = (sym_cnt_q == CNT_W'(SYM_PER_FRAME - 1));
    assign next_sym = sym_valid ? sym_in : 2'b01;

    assign sym_ready  = strobe && ((state_q == IDLE) || ((state_q == SEND) && last_ph && !last_sym));
    assign busy       = (state_q != IDLE);
    assign mod_out    = mod_out_q;
    assign sample_stb = stb_q;
    assign underrun   = underrun_q;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        sym_cnt_d  = sym_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sym_d      = sym_q;
        mod_out_d  = mod_out_q;
        underrun_d = 1'b0;
        if (strobe) begin
            case (state_q)
                IDLE: begin
                    mod_out_d = 9'd0;
                    if (sym_valid) begin
                        state_d   = SEND;
                        ph_d      = 5'd0;
                        sym_cnt_d = '0;
                        sym_d     = sym_in;
                        mod_out_d = qpsk_sample(5'd0, sym_in);
                    end
                end
                SEND: begin
                    if (!last_ph) begin
                        ph_d      = ph_q + 5'd1;
                        mod_out_d = qpsk_sample(ph_q + 5'd1, sym_q);
                    end else if (!last_sym) begin
                        ph_d       = 5'd0;
                        sym_cnt_d  = sym_cnt_q + CNT_W'(1);
                        sym_d      = next_sym;
                        underrun_d = !sym_valid;
                        mod_out_d  = qpsk_sample(5'd0, next_sym);
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                        mod_out_d = 9'd0;
                    end
                end
                GAP: begin
                    mod_out_d = 9'd0;
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    if (gap_cnt_q == GAP_W'(GAP_SAMPLES - 1)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    mod_out_d = 9'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            ph_q       <= 5'd0;
            sym_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sym_q      <= 2'b00;
            mod_out_q  <= 9'd0;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= strobe ? '0 : div_q + DIV_W'(1);
            ph_q       <= ph_d;
            sym_cnt_q  <= sym_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sym_q      <= sym_d;
            mod_out_q  <= mod_out_d;
            stb_q      <= strobe;
            underrun_q <= underrun_d;
        end
    end

`ifdef TX_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;
    logic [7:0] underrun_cnt_q;
    logic       gap_entry;

    assign gap_entry    = strobe && (state_q == SEND) && last_ph && last_sym;
    assign frame_cnt    = frame_cnt_q;
    assign underrun_cnt = underrun_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q    <= 8'd0;
            underrun_cnt_q <= 8'd0;
        end else begin
            if (gap_entry) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (underrun_d && (underrun_cnt_q != 8'hff)) begin
                underrun_cnt_q <= underrun_cnt_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qpsk_modulator.sv
// Scoreboard bench for qpsk_modulator: expected samples are queued per accepted symbol and popped on sample_stb.
module tb_qpsk_modulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic [8:0] mod_out;
    logic       sample_stb;
    logic       busy;
    logic       underrun;
`ifdef TX_FRAME_CNT_EN
    logic [7:0] frame_cnt;
    logic [7:0] underrun_cnt;
`endif

    always #5 clk = ~clk;

    qpsk_modulator dut (
        .clk          (clk),
        .reset        (reset),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .mod_out      (mod_out),
        .sample_stb   (sample_stb),
        .busy         (busy),
`ifdef TX_FRAME_CNT_EN
        .underrun     (underrun),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt)
`else
        .underrun     (underrun)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int round_r(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Reference carrier from real trig, rounded to the 120-peak table.
    function automatic logic [8:0] exp_sample(input int ph, input logic [1:0] s);
        real a;
        int  sn;
        int  cs;
        int  v;
        a  = 2.0 * 3.14159265358979 * real'(ph) / 32.0;
        sn = round_r(120.0 * $sin(a));
        cs = round_r(120.0 * $cos(a));
        v  = (s[0] ? sn : -sn) + (s[1] ? -cs : cs);
        return 9'(v);
    endfunction

    typedef struct {
        logic [8:0] samp;
        bit         und;
        bit         first;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en      = 1'b0;
    int   zero_run    = 0;
    int   frames_seen = 0;
    int   frame_samp  = 0;
    int   exp_frames  = 0;
    int   exp_und     = 0;

    task automatic push_sym(input logic [1:0] s, input bit und, input bit first);
        exp_t e;
        for (int ph = 0; ph < 32; ph++) begin
            e.samp  = exp_sample(ph, s);
            e.und   = und && (ph == 0);
            e.first = first && (ph == 0);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && sample_stb) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                if (mon_e.first) begin
                    if (frames_seen > 0) check_eq("gap_zero_samples_ge8", 32'(zero_run >= 8), 1);
                    frames_seen++;
                    frame_samp = 0;
                end
                check_eq("sample", mod_out, mon_e.samp);
                check_eq("underrun_pulse", underrun, mon_e.und);
                zero_run = 0;
                frame_samp++;
            end else begin
                check_eq("idle_zero", mod_out, 0);
                zero_run++;
            end
        end
    end

    task automatic send_sym(input logic [1:0] s, input bit vld, input bit first);
        int n = 0;
        sym_in    = s;
        sym_valid = vld;
        @(negedge clk);
        while (!sym_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("sym_ready_seen", sym_ready, 1);
        push_sym(vld ? s : 2'b01, !vld, first);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int drop_at, input bit rnd);
        logic [1:0] s;
        for (int i = 0; i < 32; i++) begin
            s = rnd ? 2'($urandom_range(0, 3)) : 2'b01;
            send_sym(s, i != drop_at, i == 0);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_eq("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("busy_dropped", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        sym_valid = 1'b0;
        sym_in    = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_mod_out", mod_out, 0);
        check_eq("rst_sample_stb", sample_stb, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_sym_ready", sym_ready, 0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Frame of all 01, then idle so busy must fall after the gap.
        send_frame(-1, 1'b0);
        sym_valid = 1'b0;
        wait_drain();
        repeat (8) @(negedge clk);
        check_eq("busy_in_gap", busy, 1);
        wait_idle();
        exp_frames++;

        // Random frame with symbol 5 missing.
        send_frame(5, 1'b1);
        exp_frames++;
        exp_und++;

        // Two more frames back to back with sym_valid held high.
        send_frame(-1, 1'b1);
        send_frame(-1, 1'b1);
        sym_valid = 1'b0;
        exp_frames += 2;
        wait_drain();
        repeat (8) @(negedge clk);
`ifdef TX_FRAME_CNT_EN
        check_eq("frame_cnt", frame_cnt, exp_frames);
        check_eq("underrun_cnt", underrun_cnt, exp_und);
`endif
        wait_idle();

        // Partial frame, then asynchronous reset around sample 300.
        for (int i = 0; i < 10; i++) send_sym(2'($urandom_range(0, 3)), 1'b1, i == 0);
        sym_valid = 1'b0;
        begin
            int n = 0;
            while (frame_samp < 300 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check_eq("reached_sample_300", 32'(frame_samp >= 300), 1);
        end
        #2;
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_eq("midrst_mod_out", mod_out, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_underrun", underrun, 0);
        check_eq("midrst_sample_stb", sample_stb, 0);
        exp_q.delete();
        frames_seen = 0;
        exp_frames  = 0;
        exp_und     = 0;
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Fresh frame after reset must start at phase 0.
        send_frame(-1, 1'b1);
        sym_valid = 1'b0;
        exp_frames++;
        wait_drain();
        repeat (8) @(negedge clk);
`ifdef TX_FRAME_CNT_EN
        check_eq("frame_cnt_after_rst", frame_cnt, exp_frames);
        check_eq("underrun_cnt_after_rst", underrun_cnt, exp_und);
`endif
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
